// File: rtl/threshold_lane_scheduler_if.sv
// threshold_lane_scheduler_if: lane-side bundle between the scheduler and its filter lanes
interface threshold_lane_scheduler_if #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH_BITS = 8,
  parameter int HEIGHT_BITS = 8
);
  logic [4:0] c_out;
  logic [NUM_LANES-1:0] lane_enable;
  logic [NUM_LANES-1:0] lane_finished;
  logic [NUM_LANES-1:0] lane_wren;
  logic [NUM_LANES*WIDTH_BITS-1:0] lane_col;
  logic [NUM_LANES*HEIGHT_BITS-1:0] lane_row;
  logic [NUM_LANES-1:0] lane_data;
  logic [NUM_LANES-1:0] lane_stall;
  modport master (
    output c_out, lane_enable, lane_stall,
    input lane_finished, lane_wren, lane_col, lane_row, lane_data
  );
  modport slave (
    input c_out, lane_enable, lane_stall,
    output lane_finished, lane_wren, lane_col, lane_row, lane_data
  );
endinterface

// File: rtl/threshold_lane_scheduler.sv
// threshold_lane_scheduler: staggers lane start-up and merges lane results through per-lane FIFOs
module threshold_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH_BITS = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int LAUNCH_GAP = 1,
  parameter int COUNT_BITS = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic [4:0] c_in,
  input  logic invert,
  threshold_lane_scheduler_if.master lanes,
  output logic [HEIGHT_BITS-1:0] oX,
  output logic [WIDTH_BITS-1:0] oY,
  output logic [2:0] oR,
  output logic [2:0] oG,
  output logic [2:0] oB,
  output logic oValid,
  output logic busy,
  output logic done,
  output logic [9:0] LEDR,
  output logic [COUNT_BITS-1:0] cycle_count
);
  localparam int EW = HEIGHT_BITS + WIDTH_BITS + 1;
  localparam int PW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int GW = $clog2(LAUNCH_GAP) + 1;
  localparam int CW = FIFO_DEPTH_BITS + 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic accept, ovf, inv, any;
  logic [GW-1:0] gap;
  logic [PW-1:0] ptr, gnt;
  logic [NUM_LANES-1:0] full, empty, push, pop;
  logic [NUM_LANES-1:0][EW-1:0] head;
  logic [3:0] code;
  assign accept = start && (state == IDLE || state == DONE);
  assign lanes.lane_stall = full;
  assign LEDR = {lanes.c_out, ovf, code};
  // state register
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  // next state plus state-decoded status; drain ends only once the last popped pixel has left
  always_comb begin
    state_nx = state;
    if (accept) state_nx = LAUNCH;
    else if (state == LAUNCH && &lanes.lane_enable) state_nx = RUN;
    else if (state == RUN && &lanes.lane_finished) state_nx = DRAIN;
    else if (state == DRAIN && &empty && !oValid) state_nx = DONE;
    busy = state == LAUNCH || state == RUN || state == DRAIN;
    done = state == DONE;
    code = state == IDLE ? 4'b0001 : state == DRAIN ? 4'b0100 : state == DONE ? 4'b1000 : 4'b0010;
  end
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_fifo
    logic [EW-1:0] mem [1 << FIFO_DEPTH_BITS];
    logic [FIFO_DEPTH_BITS-1:0] wp, rp;
    logic [CW-1:0] cnt;
    assign full[k] = cnt[FIFO_DEPTH_BITS];
    assign empty[k] = ~|cnt;
    assign push[k] = lanes.lane_wren[k] && !full[k];
    assign head[k] = mem[rp];
    // entry storage; validity is tracked by occupancy, so contents need no reset
    always_ff @(posedge clock)
      if (push[k]) mem[wp] <= {lanes.lane_row[k*HEIGHT_BITS +: HEIGHT_BITS], lanes.lane_col[k*WIDTH_BITS +: WIDTH_BITS], lanes.lane_data[k]};
    // pointers and occupancy
    always_ff @(posedge clock) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push[k]) wp <= wp + 1'b1;
        if (pop[k]) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push[k]) - CW'(pop[k]);
      end
    end
  end
  // round-robin: first non-empty FIFO at or after the priority pointer
  always_comb begin
    gnt = '0;
    any = 1'b0;
    pop = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!empty[(int'(ptr) + i) % NUM_LANES]) begin
        gnt = PW'((int'(ptr) + i) % NUM_LANES);
        any = 1'b1;
      end
    end
    if (any) pop[gnt] = 1'b1;
  end
  // run control, staggered lane launch, arbiter pointer and registered pixel output
  always_ff @(posedge clock) begin
    if (reset) begin
      lanes.c_out <= '0;
      lanes.lane_enable <= '0;
      inv <= 1'b0;
      ovf <= 1'b0;
      gap <= '0;
      ptr <= '0;
      cycle_count <= '0;
      oX <= '0;
      oY <= '0;
      oR <= '0;
      oG <= '0;
      oB <= '0;
      oValid <= 1'b0;
    end else begin
      oValid <= any;
      if (any) begin
        oX <= head[gnt][EW-1 -: HEIGHT_BITS];
        oY <= head[gnt][WIDTH_BITS:1];
        oR <= {3{head[gnt][0] ^ inv}};
        oG <= {3{head[gnt][0] ^ inv}};
        oB <= {3{head[gnt][0] ^ inv}};
        ptr <= int'(gnt) == NUM_LANES - 1 ? '0 : gnt + 1'b1;
      end
      if (|(lanes.lane_wren & full)) ovf <= 1'b1;
      if (busy && !(&cycle_count)) cycle_count <= cycle_count + 1'b1;
      if (state == LAUNCH && !(&lanes.lane_enable)) begin
        gap <= gap == GW'(LAUNCH_GAP - 1) ? '0 : gap + 1'b1;
        if (gap == GW'(LAUNCH_GAP - 1)) lanes.lane_enable <= (lanes.lane_enable << 1) | NUM_LANES'(1);
      end
      if (accept) begin
        lanes.c_out <= c_in;
        inv <= invert;
        lanes.lane_enable <= '0;
        cycle_count <= '0;
        ovf <= 1'b0;
        ptr <= '0;
        gap <= '0;
      end
    end
  end
endmodule
